// File: rtl/cpu_boot_sequencer.sv
// Boot and interrupt sequencer for the 6502 subsystem: holds the CPU in reset,
// streams a program image into RAM, then releases the CPU and paces N_IRQ active-low lines.
module cpu_boot_sequencer #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int N_IRQ    = 2,
   parameter int CNT_W    = 16,
   parameter int HOLD_CYC = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ADDR_W:0]        length,
   input  logic                   s_valid,
   input  logic [DATA_W-1:0]      s_data,
   output logic                   s_ready,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_data,
   output logic                   mem_we,
   output logic                   cpu_rst_n,
   input  logic [N_IRQ-1:0]       irq_en,
   input  logic [N_IRQ-1:0]       irq_oneshot,
   input  logic [N_IRQ*CNT_W-1:0] irq_period,
   input  logic [N_IRQ*CNT_W-1:0] irq_width,
   output logic [N_IRQ-1:0]       irq_n,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, HOLD, LOAD, RUN} state_t;

   localparam int                HC_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYC - 1);
   localparam logic [HC_W-1:0]   HC_ONE    = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_W:0]   REM_ONE   = 1;
   localparam logic [CNT_W-1:0]  CNT_ONE   = 1;

   state_t              state_q, state_d;
   logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     remain_q, remain_d;
   logic                s_ready_q, s_ready_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_data_q, mem_data_d;
   logic                cpu_rst_n_q, cpu_rst_n_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [N_IRQ-1:0]    irq_n_q, irq_n_d;
   logic [CNT_W-1:0]    ch_cnt_q [N_IRQ];
   logic [CNT_W-1:0]    ch_cnt_d [N_IRQ];
   logic [N_IRQ-1:0]    ch_low_q, ch_low_d;
   logic [N_IRQ-1:0]    ch_fired_q, ch_fired_d;

   logic [CNT_W-1:0]    ch_width [N_IRQ];
   logic [CNT_W-1:0]    ch_high  [N_IRQ];

   logic start_ok;
   logic xfer;
   logic run_entry;

   assign start_ok  = start && ((state_q == IDLE) || (state_q == RUN));
   assign xfer      = s_valid && s_ready_q;
   // LOAD with nothing left to write is the single settling cycle before RUN,
   // which keeps the CPU release one cycle clear of the last RAM write.
   assign run_entry = (state_q == LOAD) && (remain_q == '0);

   for (genvar g = 0; g < N_IRQ; g++) begin : g_cfg
      assign ch_width[g] = irq_width[g*CNT_W +: CNT_W];
      assign ch_high[g]  = (irq_period[g*CNT_W +: CNT_W] == '0) ? CNT_ONE
                                                                : irq_period[g*CNT_W +: CNT_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         addr_q      <= '0;
         remain_q    <= '0;
         s_ready_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         cpu_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         irq_n_q     <= '1;
         ch_low_q    <= '0;
         ch_fired_q  <= '0;
         for (int i = 0; i < N_IRQ; i++) ch_cnt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         addr_q      <= addr_d;
         remain_q    <= remain_d;
         s_ready_q   <= s_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         irq_n_q     <= irq_n_d;
         ch_low_q    <= ch_low_d;
         ch_fired_q  <= ch_fired_d;
         for (int i = 0; i < N_IRQ; i++) ch_cnt_q[i] <= ch_cnt_d[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      if (start_ok) begin
         state_d    = HOLD;
         hold_cnt_d = '0;
         addr_d     = base_addr;
         remain_d   = length;
      end else begin
         case (state_q)
            HOLD: begin
               if (hold_cnt_q == HOLD_LAST) state_d = LOAD;
               else hold_cnt_d = hold_cnt_q + HC_ONE;
            end
            LOAD: begin
               if (remain_q == '0) begin
                  state_d = RUN;
               end else if (xfer) begin
                  addr_d   = addr_q + ADDR_ONE;
                  remain_d = remain_q - REM_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      s_ready_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      cpu_rst_n_d = cpu_rst_n_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      if (start_ok) begin
         cpu_rst_n_d = 1'b0;
         busy_d      = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               cpu_rst_n_d = 1'b0;
               busy_d      = 1'b0;
            end
            HOLD: begin
               cpu_rst_n_d = 1'b0;
               busy_d      = 1'b1;
               if (hold_cnt_q == HOLD_LAST) s_ready_d = (remain_q != '0);
            end
            LOAD: begin
               if (remain_q == '0) begin
                  cpu_rst_n_d = 1'b1;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  s_ready_d = !(xfer && (remain_q == REM_ONE));
                  if (xfer) begin
                     mem_we_d   = 1'b1;
                     mem_addr_d = addr_q;
                     mem_data_d = s_data;
                  end
               end
            end
            RUN: begin
               cpu_rst_n_d = 1'b1;
               busy_d      = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Each channel counts the remaining cycles of its current phase down to 1;
   // a counter of 0 marks a channel that has not started a phase yet.
   always_comb begin
      irq_n_d    = irq_n_q;
      ch_low_d   = ch_low_q;
      ch_fired_d = ch_fired_q;
      for (int i = 0; i < N_IRQ; i++) ch_cnt_d[i] = ch_cnt_q[i];
      for (int i = 0; i < N_IRQ; i++) begin
         if ((state_q == RUN) && !start_ok) begin
            if (!irq_en[i]) begin
               ch_cnt_d[i] = '0;
               ch_low_d[i] = 1'b0;
               irq_n_d[i]  = 1'b1;
            end else if (ch_fired_q[i]) begin
               irq_n_d[i] = 1'b1;
            end else if (ch_cnt_q[i] == '0) begin
               ch_cnt_d[i] = ch_high[i];
               ch_low_d[i] = 1'b0;
               irq_n_d[i]  = 1'b1;
            end else if (ch_cnt_q[i] == CNT_ONE) begin
               if (ch_low_q[i]) begin
                  ch_low_d[i] = 1'b0;
                  irq_n_d[i]  = 1'b1;
                  if (irq_oneshot[i]) begin
                     ch_fired_d[i] = 1'b1;
                     ch_cnt_d[i]   = '0;
                  end else begin
                     ch_cnt_d[i] = ch_high[i];
                  end
               end else if (ch_width[i] != '0) begin
                  ch_low_d[i] = 1'b1;
                  ch_cnt_d[i] = ch_width[i];
                  irq_n_d[i]  = 1'b0;
               end else begin
                  ch_cnt_d[i] = ch_high[i];
               end
            end else begin
               ch_cnt_d[i] = ch_cnt_q[i] - CNT_ONE;
            end
         end else if (run_entry) begin
            ch_cnt_d[i]   = ch_high[i];
            ch_low_d[i]   = 1'b0;
            ch_fired_d[i] = 1'b0;
            irq_n_d[i]    = 1'b1;
         end else begin
            ch_cnt_d[i]   = '0;
            ch_low_d[i]   = 1'b0;
            ch_fired_d[i] = 1'b0;
            irq_n_d[i]    = 1'b1;
         end
      end
   end

   assign s_ready   = s_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign irq_n     = irq_n_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed self-checking bench for cpu_boot_sequencer: image loads, stalls, wrap,
// periodic and one-shot interrupts, restart from RUN and reset during a load.
module tb_cpu_boot_sequencer;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 8;
   localparam int N_IRQ    = 2;
   localparam int CNT_W    = 16;
   localparam int HOLD_CYC = 10;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [ADDR_W-1:0]      base_addr;
   logic [ADDR_W:0]        length;
   logic                   s_valid;
   logic [DATA_W-1:0]      s_data;
   logic                   s_ready;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_data;
   logic                   mem_we;
   logic                   cpu_rst_n;
   logic [N_IRQ-1:0]       irq_en;
   logic [N_IRQ-1:0]       irq_oneshot;
   logic [N_IRQ*CNT_W-1:0] irq_period;
   logic [N_IRQ*CNT_W-1:0] irq_width;
   logic [N_IRQ-1:0]       irq_n;
   logic                   busy;
   logic                   done;

   int checks = 0;
   int errors = 0;
   logic [7:0] img [8];

   cpu_boot_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_IRQ(N_IRQ), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .cpu_rst_n(cpu_rst_n),
      .irq_en(irq_en), .irq_oneshot(irq_oneshot), .irq_period(irq_period),
      .irq_width(irq_width), .irq_n(irq_n), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Every step lands on a falling edge: outputs of the last rising edge are
   // stable there, and inputs set there are sampled by the next rising edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [15:0] base, input logic [16:0] len);
      start     = 1'b1;
      base_addr = base;
      length    = len;
      tick();
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
      checkOutput({tag, "_irq_n"},     32'(irq_n),     32'h3);
      checkOutput({tag, "_mem_we"},    32'(mem_we),    32'd0);
      checkOutput({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      checkOutput({tag, "_mem_data"},  32'(mem_data),  32'd0);
      checkOutput({tag, "_s_ready"},   32'(s_ready),   32'd0);
      checkOutput({tag, "_busy"},      32'(busy),      32'd0);
      checkOutput({tag, "_done"},      32'(done),      32'd0);
   endtask

   // Called right after the start edge; streams img[0..n-1] with s_valid held high.
   task automatic loadContiguous(input logic [15:0] base, input int n, input bit poke);
      logic [15:0] ea;
      s_valid = 1'b1;
      s_data  = img[0];
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_rst", 32'(cpu_rst_n), 32'd0);
      for (int k = 1; k < HOLD_CYC; k++) begin
         if (poke && k == 3) begin
            start     = 1'b1;
            base_addr = 16'h1234;
            length    = 17'd1;
         end
         tick();
         start = 1'b0;
         checkOutput("hold_ready", 32'(s_ready), 32'd0);
         checkOutput("hold_busy", 32'(busy), 32'd1);
         checkOutput("hold_we", 32'(mem_we), 32'd0);
         checkOutput("hold_rst", 32'(cpu_rst_n), 32'd0);
      end
      tick();
      checkOutput("load_ready", 32'(s_ready), 32'd1);
      for (int k = 0; k < n; k++) begin
         s_data = img[k];
         tick();
         ea = base + 16'(k);
         checkOutput("wr_we", 32'(mem_we), 32'd1);
         checkOutput("wr_addr", 32'(mem_addr), 32'(ea));
         checkOutput("wr_data", 32'(mem_data), 32'(img[k]));
         checkOutput("wr_rst", 32'(cpu_rst_n), 32'd0);
         checkOutput("wr_ready", 32'(s_ready), 32'(k < n - 1));
      end
      s_data = 8'hEE;
      tick();
      checkOutput("entry_we", 32'(mem_we), 32'd0);
      checkOutput("entry_rst", 32'(cpu_rst_n), 32'd1);
      checkOutput("entry_done", 32'(done), 32'd1);
      checkOutput("entry_busy", 32'(busy), 32'd0);
      checkOutput("entry_ready", 32'(s_ready), 32'd0);
      checkOutput("entry_irq", 32'(irq_n), 32'h3);
      s_valid = 1'b0;
      tick();
      checkOutput("run_done", 32'(done), 32'd0);
      checkOutput("run_rst", 32'(cpu_rst_n), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lows0;
      int lows1;
      int writes;
      int n;
      logic hs;
      logic [4:0] pat;

      rst         = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      length      = '0;
      s_valid     = 1'b0;
      s_data      = '0;
      irq_en      = 2'b01;
      irq_oneshot = 2'b00;
      irq_period  = {16'd5, 16'd300};
      irq_width   = {16'd4, 16'd2};
      tick();
      tick();
      checkResetValues("reset");
      rst = 1'b0;
      tick();

      $display("[TB] boot 4 bytes at 0x0200");
      img[0] = 8'hA9; img[1] = 8'h05; img[2] = 8'h85; img[3] = 8'h10;
      applyStimulus(16'h0200, 17'd4);
      loadContiguous(16'h0200, 4, 1'b0);

      // Positioned after RUN-entry edge E plus one; k tracks the edge offset from E.
      $display("[TB] periodic irq on channel 0");
      lows0 = 0;
      lows1 = 0;
      for (int k = 2; k <= 605; k++) begin
         tick();
         if (irq_n[0] == 1'b0) lows0++;
         if (irq_n[1] == 1'b0) lows1++;
         if (k == 299) checkOutput("per_high_299", 32'(irq_n), 32'h3);
         if (k == 300) checkOutput("per_low_300", 32'(irq_n), 32'h2);
         if (k == 301) checkOutput("per_low_301", 32'(irq_n), 32'h2);
         if (k == 302) checkOutput("per_high_302", 32'(irq_n), 32'h3);
         if (k == 601) checkOutput("per_high_601", 32'(irq_n), 32'h3);
         if (k == 602) checkOutput("per_low_602", 32'(irq_n), 32'h2);
         if (k == 604) checkOutput("per_high_604", 32'(irq_n), 32'h3);
      end
      checkOutput("per_low_count", 32'(lows0), 32'd4);
      checkOutput("per_ch1_quiet", 32'(lows1), 32'd0);

      $display("[TB] one-shot with mid-pulse disable on channel 1");
      irq_oneshot = 2'b10;
      irq_en      = 2'b10;
      tick();
      for (int j = 1; j <= 4; j++) tick();
      checkOutput("os_high_x4", 32'(irq_n), 32'h3);
      tick();
      checkOutput("os_low_x5", 32'(irq_n), 32'h1);
      tick();
      checkOutput("os_low_x6", 32'(irq_n), 32'h1);
      irq_en = 2'b00;
      tick();
      checkOutput("os_disabled", 32'(irq_n), 32'h3);
      tick();
      tick();
      irq_en = 2'b10;
      tick();
      lows1 = 0;
      for (int j = 1; j <= 40; j++) begin
         tick();
         if (irq_n[1] == 1'b0) lows1++;
         if (j == 4) checkOutput("os_re_high4", 32'(irq_n[1]), 32'd1);
         if (j == 5) checkOutput("os_re_low5", 32'(irq_n[1]), 32'd0);
         if (j == 8) checkOutput("os_re_low8", 32'(irq_n[1]), 32'd0);
         if (j == 9) checkOutput("os_re_high9", 32'(irq_n[1]), 32'd1);
      end
      checkOutput("os_pulse_cycles", 32'(lows1), 32'd4);

      $display("[TB] restart from RUN with a stalled stream");
      irq_oneshot = 2'b00;
      irq_period  = {16'd5, 16'd3};
      irq_width   = {16'd4, 16'd4};
      irq_en      = 2'b01;
      tick();
      tick();
      tick();
      tick();
      checkOutput("rs_low_z3", 32'(irq_n), 32'h2);
      tick();
      checkOutput("rs_low_z4", 32'(irq_n), 32'h2);
      img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
      applyStimulus(16'h0300, 17'd3);
      checkOutput("rs_cpu_rst", 32'(cpu_rst_n), 32'd0);
      checkOutput("rs_irq_high", 32'(irq_n), 32'h3);
      checkOutput("rs_busy", 32'(busy), 32'd1);
      for (int k = 1; k < HOLD_CYC; k++) tick();
      checkOutput("rs_hold_ready", 32'(s_ready), 32'd0);
      tick();
      checkOutput("rs_load_ready", 32'(s_ready), 32'd1);
      pat    = 5'b10101;
      n      = 0;
      writes = 0;
      for (int c = 0; c < 5; c++) begin
         s_valid = pat[c];
         s_data  = img[n];
         tick();
         hs = pat[c] && (n < 3);
         checkOutput("st_we", 32'(mem_we), 32'(hs));
         if (hs) begin
            checkOutput("st_addr", 32'(mem_addr), 32'h0300 + 32'(n));
            checkOutput("st_data", 32'(mem_data), 32'(img[n]));
            n++;
         end
         writes += int'(mem_we);
         checkOutput("st_ready", 32'(s_ready), 32'(n < 3));
      end
      s_valid = 1'b1;
      s_data  = 8'hEE;
      tick();
      writes += int'(mem_we);
      checkOutput("st_entry_we", 32'(mem_we), 32'd0);
      checkOutput("st_entry_rst", 32'(cpu_rst_n), 32'd1);
      checkOutput("st_entry_done", 32'(done), 32'd1);
      tick();
      writes += int'(mem_we);
      checkOutput("st_done_clear", 32'(done), 32'd0);
      checkOutput("st_write_count", 32'(writes), 32'd3);
      s_valid = 1'b0;

      $display("[TB] address wrap with start ignored during HOLD");
      img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
      applyStimulus(16'hFFFE, 17'd4);
      loadContiguous(16'hFFFE, 4, 1'b1);

      $display("[TB] reset during LOAD, then zero-length boot");
      img[0] = 8'h5A; img[1] = 8'h6B; img[2] = 8'h7C; img[3] = 8'h8D;
      s_valid = 1'b1;
      s_data  = img[0];
      applyStimulus(16'h0400, 17'd4);
      for (int k = 1; k <= HOLD_CYC; k++) tick();
      tick();
      checkOutput("rl_we0", 32'(mem_we), 32'd1);
      checkOutput("rl_addr0", 32'(mem_addr), 32'h0400);
      s_data = img[1];
      tick();
      checkOutput("rl_addr1", 32'(mem_addr), 32'h0401);
      rst = 1'b1;
      tick();
      checkResetValues("midload_rst");
      rst     = 1'b0;
      s_valid = 1'b0;
      tick();
      tick();
      checkOutput("idle_rst", 32'(cpu_rst_n), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      applyStimulus(16'h0500, 17'd0);
      checkOutput("z_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= HOLD_CYC; k++) begin
         tick();
         checkOutput("z_wait_rst", 32'(cpu_rst_n), 32'd0);
         checkOutput("z_wait_we", 32'(mem_we), 32'd0);
         checkOutput("z_wait_ready", 32'(s_ready), 32'd0);
      end
      tick();
      checkOutput("z_entry_rst", 32'(cpu_rst_n), 32'd1);
      checkOutput("z_entry_done", 32'(done), 32'd1);
      checkOutput("z_entry_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("z_done_clear", 32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_boot_sequencer.md
# cpu_boot_sequencer

Synthesizable boot and interrupt sequencer for the 6502 subsystem. It holds the CPU in reset and streams a program image into system RAM through its single write port. It then releases the CPU and drives N independent active-low interrupt/soft-reset lines, each with a programmable periodic or one-shot pulse pattern. It sits between the RAM arbiter's write side and the CPU reset/interrupt pins, and can be re-armed at run time to reload and restart.

## Interface
- ADDR_W, 16, RAM address width; image address wraps modulo 2^ADDR_W
- DATA_W, 8, RAM data width
- N_IRQ, 2, number of interrupt channels
- CNT_W, 16, width of per-channel phase counters
- HOLD_CYC, 10, cycles CPU reset is held before first write (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to (re)load and boot
- base_addr  in  ADDR_W  first RAM address of image, latched on accepted start
- length  in  ADDR_W+1  image byte count, latched on accepted start; 0 = boot without load
- s_valid  in  1  image byte valid
- s_data  in  DATA_W  image byte
- s_ready  out  1  sequencer accepts byte; transfer when s_valid & s_ready at clk edge
- mem_addr  out  ADDR_W  RAM write address
- mem_data  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- cpu_rst_n  out  1  CPU reset, low = held
- irq_en  in  N_IRQ  per-channel enable
- irq_oneshot  in  N_IRQ  1 = fire once per boot, 0 = periodic
- irq_period  in  N_IRQ*CNT_W  per-channel high-phase length in cycles (channel i at [i*CNT_W +: CNT_W])
- irq_width  in  N_IRQ*CNT_W  per-channel low-pulse length in cycles
- irq_n  out  N_IRQ  active-low interrupt lines
- busy  out  1  high in HOLD and LOAD
- done  out  1  one-cycle pulse on entry to RUN

## Operation
- All outputs are registered. Reset values: cpu_rst_n=0, irq_n=all 1, mem_we=0, mem_addr=0, mem_data=0, s_ready=0, busy=0, done=0. State goes to IDLE.
- States: IDLE, HOLD, LOAD, RUN.
- IDLE: cpu_rst_n=0. An accepted start latches base_addr and length, then → HOLD.
- HOLD: cpu_rst_n=0, busy=1, for exactly HOLD_CYC cycles. Then → LOAD if length≠0, else → RUN.
- LOAD: s_ready=1 until the length-th byte is accepted. Byte k (0-based) is written to base_addr+k mod 2^ADDR_W. After the last write → RUN.
- RUN: cpu_rst_n=1. Channel timers run as described below.
- A start in RUN or IDLE is accepted. A start in HOLD or LOAD is ignored.
- A start in RUN drops cpu_rst_n, forces all irq_n to 1, clears all timers, and → HOLD.
- Channel i (RUN only, enabled):
  - High phase lasts max(irq_period,1) cycles; low phase lasts irq_width cycles; the pattern then repeats.
  - irq_width=0: the line never asserts.
  - oneshot: after the first low phase the line stays high until the next boot.
- irq_en low: irq_n=1 on the next cycle and the channel counter clears. When re-enabled, the channel starts a fresh high phase.
- Config inputs are sampled live each cycle. Changing a value takes effect at the next phase boundary; the current phase completes using the length it started with.
- rst mid-operation aborts immediately. Already-written bytes remain in RAM.

## Timing
- start sampled at edge T → busy=1 and state HOLD after T. After edge T+HOLD_CYC, LOAD begins with s_ready=1.
- Handshake at edge k → mem_we/mem_addr/mem_data for that byte are visible for one cycle after edge k. Throughput is 1 byte/cycle, and stalls with no s_valid produce no write.
- s_ready is 0 in the cycle after the last handshake, so no extra byte is consumed.
- Last handshake at edge L → mem_we=0, cpu_rst_n=1, done=1, busy=0 after edge L+1; done=0 after L+2.
- cpu_rst_n never rises in the same cycle as a write.
- length=0 → RUN entered HOLD_CYC+1 edges after T.
- Channel timers count from edge L+1 (or the RUN-entry edge). With period P and width W, the first irq_n falling edge is after edge L+1+P and lasts W cycles.
- length max (2^ADDR_W) writes the full space. Further wrap is impossible.

## Test plan
- Boot 4 bytes: base=0x0200, length=4, data A9 05 85 10, s_valid held high → writes 0x0200..0x0203 on consecutive cycles, HOLD exactly 10 cycles, cpu_rst_n=1 one cycle after last mem_we, done single pulse.
- Stalled stream: s_valid toggling every other cycle, length=3 → exactly 3 writes, no write on idle cycles, s_ready low after 3rd handshake even with s_valid high.
- Wrap: base=0xFFFE, length=4 → writes to FFFE, FFFF, 0000, 0001.
- Periodic IRQ: ch0 period=300, width=2, oneshot=0; ch1 disabled → ch0 low 2 cycles every 302 cycles starting 300 cycles after RUN entry; irq_n[1] stays 1.
- One-shot plus mid-pulse disable: ch1 oneshot, period=5, width=4. Drop irq_en mid-pulse → irq_n[1]=1 next cycle. Re-enable → exactly one new pulse after 5 cycles.
- Restart and reset: start asserted in RUN → cpu_rst_n=0 and irq_n=all 1 next cycle, reload proceeds. rst asserted mid-LOAD → all outputs at reset values after the next edge, state IDLE.
